mmio_uart_tx: RTL and testbench

Memory-mapped serial console transmitter on the CPU data-memory port, alongside the data cache. It captures stores from the memory stage to its register window, buffers the bytes in a FIFO and serialises them as 8N1 frames on `txd`. Software polls a status register to learn the FIFO level. The block gives the core its only observable output stream.

---
 rtl/mmio_uart_tx.sv | 229 ++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: register window, transmit FIFO and 8N1 serialiser.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
//
// state  | meaning
// IDLE   | line high, pops the next byte as soon as the FIFO is non-empty
// START  | start bit (txd=0) for one bit period
// DATA   | eight data bits, LSB first, one bit period each
// PARITY | even parity of the data byte (parity build only)
// STOP   | stop bit (txd=1) for one bit period

module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
    parameter int          FIFO_DEPTH    = 16,
    parameter logic [15:0] DIVISOR_RESET = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        write_en,
    input  logic [31:0] write_data,
    input  logic        read_en,
    output logic [31:0] read_data,
    output logic        txd,
    output logic        tx_active
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   div_q, div_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [15:0]   bit_cnt_q, bit_cnt_d;
    logic          txd_q, txd_d;
    logic          active_q, active_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          hit;
    logic [1:0]    reg_sel;
    logic          push, push_ok, pop;
    logic          full, empty;
    logic [15:0]   eff_div;
    logic          bit_done;
    logic [15:0]   count_ext;
    logic [31:0]   status_word;
    logic [7:0]    head_byte;
    logic          unused_bits;

    assign unused_bits = ^{addr[1:0], write_data[31:16]};

    assign hit      = (addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel  = addr[3:2];
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push     = write_en && hit && (reg_sel == 2'd0);
    // Full is judged on the pre-edge count, so a same-cycle pop does not rescue the push.
    assign push_ok  = push && !full;
    assign pop      = (state_q == S_IDLE) && !empty;
    assign head_byte = fifo_mem_q[rd_ptr_q];
    assign bit_done = (bit_cnt_q == 16'd1);

    assign count_ext   = 16'(count_q);
    assign status_word = {16'h0000, count_ext[7:0], 3'b000, PARITY_EN, ovf_q,
                          (state_q != S_IDLE), empty, full};

    always_comb begin
        div_d = div_q;
        if (write_en && hit && (reg_sel == 2'd2)) begin
            div_d = write_data[15:0];
        end
        // Reloads use the incoming value so a bit starting right after a write sees it.
        eff_div = (div_d == 16'd0) ? 16'd1 : div_d;
    end

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (read_en && hit && (reg_sel == 2'd1)) begin
            ovf_d = 1'b0;
        end
        if (push && full) begin
            ovf_d = 1'b1;
        end

        rdata_d = rdata_q;
        if (read_en) begin
            rdata_d = 32'h0;
            if (hit) begin
                case (reg_sel)
                    2'd1:    rdata_d = status_word;
                    2'd2:    rdata_d = {16'h0000, div_q};
                    default: rdata_d = 32'h0;
                endcase
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_d     = par_q;
        bit_idx_d = bit_idx_q;
        bit_cnt_d = bit_cnt_q;

        if (state_q != S_IDLE) begin
            bit_cnt_d = bit_done ? eff_div : bit_cnt_q - 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    shift_d   = head_byte;
                    par_d     = ^head_byte;
                    bit_cnt_d = eff_div;
                    bit_idx_d = 3'd0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = par_d;
            default:  txd_d = 1'b1;
        endcase

        active_d = (state_d != S_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q] <= write_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            div_q     <= DIVISOR_RESET;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            bit_idx_q <= 3'd0;
            bit_cnt_q <= 16'd1;
            txd_q     <= 1'b1;
            active_q  <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            div_q     <= div_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            bit_idx_q <= bit_idx_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
            active_q  <= active_d;
            rdata_q   <= rdata_d;
        end
    end

    assign read_data = rdata_q;
    assign txd       = txd_q;
    assign tx_active = active_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register vector table plus frame, burst, overflow,
// divisor-change and reset sequences with hand-built expected line waveforms.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] A_TX  = BASE;
    localparam logic [31:0] A_ST  = BASE + 32'h4;
    localparam logic [31:0] A_DIV = BASE + 32'h8;
    localparam logic [31:0] A_RSV = BASE + 32'hC;
    localparam logic [31:0] A_MISS = BASE + 32'h10;

`ifdef UART_TX_PARITY_EN
    localparam logic [31:0] PB  = 32'h10;
    localparam bit          PAR = 1'b1;
`else
    localparam logic [31:0] PB  = 32'h0;
    localparam bit          PAR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        write_en;
    logic [31:0] write_data;
    logic        read_en;
    logic [31:0] read_data;
    logic        txd;
    logic        tx_active;

    mmio_uart_tx dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .write_en   (write_en),
        .write_data (write_data),
        .read_en    (read_en),
        .read_data  (read_data),
        .txd        (txd),
        .tx_active  (tx_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        bit          re;
        logic [31:0] a;
        logic [31:0] d;
        bit          chk;
        logic [31:0] e;
        string       nm;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;
    int   k = 0;
    bit   exp_txd[$];
    bit   exp_act[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (k < exp_txd.size()) begin
            check($sformatf("txd[%0d]", k), {31'b0, txd}, {31'b0, exp_txd[k]});
            check($sformatf("tx_active[%0d]", k), {31'b0, tx_active}, {31'b0, exp_act[k]});
        end
        k++;
    endtask

    task automatic drive(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d);
        write_en   = we;
        read_en    = re;
        addr       = a;
        write_data = d;
        step();
        write_en   = 1'b0;
        read_en    = 1'b0;
        addr       = 32'h0;
        write_data = 32'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] expv, input string name);
        drive(1'b0, 1'b1, a, 32'h0);
        check(name, read_data, expv);
    endtask

    function automatic void add(input bit we, input bit re, input logic [31:0] a,
                                input logic [31:0] d, input bit chk, input logic [31:0] e,
                                input string nm);
        vec_t v;
        v.we = we; v.re = re; v.a = a; v.d = d; v.chk = chk; v.e = e; v.nm = nm;
        vecs.push_back(v);
    endfunction

    function automatic void push_bits(input bit v, input int n, input bit act);
        for (int i = 0; i < n; i++) begin
            exp_txd.push_back(v);
            exp_act.push_back(act);
        end
    endfunction

    // Slots are start, data0..7, [parity], stop; the first n_first slots last d_first clocks.
    function automatic void push_frame(input logic [7:0] b, input int n_first,
                                       input int d_first, input int d_rest);
        int nslots;
        bit v;
        nslots = PAR ? 11 : 10;
        for (int s = 0; s < nslots; s++) begin
            if (s == 0)                v = 1'b0;
            else if (s <= 8)           v = b[s-1];
            else if (PAR && (s == 9))  v = ^b;
            else                       v = 1'b1;
            push_bits(v, (s < n_first) ? d_first : d_rest, 1'b1);
        end
    endfunction

    function automatic void clear_exp();
        exp_txd.delete();
        exp_act.delete();
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        addr       = 32'h0;
        write_en   = 1'b0;
        write_data = 32'h0;
        read_en    = 1'b0;

        repeat (3) step();
        rst = 1'b0;
        check("reset_txd", {31'b0, txd}, 32'h1);
        check("reset_tx_active", {31'b0, tx_active}, 32'h0);
        check("reset_read_data", read_data, 32'h0);

        add(0, 1, A_ST,    32'h0,         1, 32'h2 | PB,   "status_reset");
        add(0, 1, A_DIV,   32'h0,         1, 32'd868,      "div_reset");
        add(1, 0, A_DIV,   32'h1234,      0, 32'h0,        "wr_div");
        add(0, 1, A_DIV,   32'h0,         1, 32'h1234,     "div_rw");
        add(0, 1, A_MISS,  32'h0,         1, 32'h0,        "read_miss");
        add(0, 1, A_TX,    32'h0,         1, 32'h0,        "txdata_read");
        add(1, 0, A_RSV,   32'hFFFF,      0, 32'h0,        "wr_rsv");
        add(0, 1, A_RSV,   32'h0,         1, 32'h0,        "rsv_read");
        add(0, 1, A_DIV,   32'h0,         1, 32'h1234,     "div_after_rsv");
        add(1, 0, A_MISS,  32'h77,        0, 32'h0,        "wr_miss");
        add(0, 1, A_ST,    32'h0,         1, 32'h2 | PB,   "status_after_miss");
        add(1, 0, A_DIV+1, 32'hABCD_0005, 0, 32'h0,        "wr_div_offset");
        add(0, 1, A_DIV+3, 32'h0,         1, 32'h5,        "div_lowbits");
        add(1, 1, A_DIV,   32'h4,         1, 32'h5,        "simul_rw_old");
        add(0, 1, A_DIV,   32'h0,         1, 32'h4,        "simul_rw_new");
        add(0, 0, 32'h0,   32'h0,         1, 32'h4,        "rdata_hold");
        add(0, 1, 32'h2000_0004, 32'h0,   1, 32'h0,        "read_miss_hi");

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].we, vecs[i].re, vecs[i].a, vecs[i].d);
            if (vecs[i].chk) check(vecs[i].nm, read_data, vecs[i].e);
        end

        // Single frame at divisor 4.
        clear_exp();
        push_bits(1'b1, 1, 1'b1);
        push_frame(8'hA5, 0, 0, 4);
        push_bits(1'b1, 1, 1'b0);
        k = 0;
        wr(A_TX, 32'hA5);
        while (k < exp_txd.size()) step();

        // Burst at divisor 1.
        clear_exp();
        wr(A_DIV, 32'h1);
        push_bits(1'b1, 1, 1'b1);
        push_frame(8'h01, 0, 0, 1);
        push_bits(1'b1, 1, 1'b1);
        push_frame(8'h02, 0, 0, 1);
        push_bits(1'b1, 1, 1'b1);
        push_frame(8'h03, 0, 0, 1);
        push_bits(1'b1, 1, 1'b0);
        k = 0;
        wr(A_TX, 32'h01);
        wr(A_TX, 32'h02);
        wr(A_TX, 32'h03);
        rd(A_ST, 32'h0000_0204 | PB, "burst_count");
        while (k < exp_txd.size()) step();

        // Overflow at divisor 100.
        clear_exp();
        wr(A_DIV, 32'd100);
        for (int i = 0; i < 18; i++) wr(A_TX, 32'(i));
        rd(A_ST, 32'h0000_100D | PB, "ovf_status");
        rd(A_ST, 32'h0000_1005 | PB, "ovf_cleared");
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("ovf_rst_txd", {31'b0, txd}, 32'h1);

        // Divisor 0, then a change to 3 in the middle of the data bits.
        wr(A_DIV, 32'h0);
        rd(A_DIV, 32'h0, "div_zero_stored");
        push_bits(1'b1, 1, 1'b1);
        push_frame(8'h0F, 3, 1, 3);
        push_bits(1'b1, 1, 1'b0);
        k = 0;
        wr(A_TX, 32'h0F);
        step();
        step();
        step();
        wr(A_DIV, 32'h3);
        while (k < exp_txd.size()) step();
        clear_exp();
        rd(A_DIV, 32'h3, "div_changed");

        // Reset during DATA with bytes still queued.
        wr(A_TX, 32'h5A);
        wr(A_TX, 32'h11);
        wr(A_TX, 32'h22);
        repeat (8) step();
        check("middata_txd_active", {31'b0, tx_active}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_txd", {31'b0, txd}, 32'h1);
        check("midrst_tx_active", {31'b0, tx_active}, 32'h0);
        rd(A_ST, 32'h2 | PB, "status_after_rst");
        rd(A_DIV, 32'd868, "div_after_rst");
        wr(A_MISS, 32'h55);
        repeat (3) step();
        check("miss_txd", {31'b0, txd}, 32'h1);
        check("miss_tx_active", {31'b0, tx_active}, 32'h0);
        rd(A_ST, 32'h2 | PB, "status_after_miss_wr");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
